// File: rtl/chunk_scheduler_pkg.sv
// Shared types and constants for the chunk scheduler: FSM states, redraw modes,
// frame geometry, cell codes and the linear board-address helper.
package chunk_pkg;

    localparam int CHUNK_SIZE = 16;
    localparam int CHUNK_COLS = 40;
    localparam int CHUNK_ROWS = 30;
    localparam int X_W        = 6;
    localparam int Y_W        = 5;
    localparam int ADDR_W     = 11;

    localparam logic [1:0] EMPTY      = 2'd0;
    localparam logic [1:0] FILL       = 2'd1;
    localparam logic [1:0] FRAME      = 2'd2;
    localparam logic [1:0] FRAME_FILL = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        DRAW  = 3'd3,
        NEXT  = 3'd4
    } state_e;

    typedef enum logic {
        FULL   = 1'b0,
        SINGLE = 1'b1
    } mode_e;

    // Row-major linear board address of chunk (x, y).
    function automatic logic [ADDR_W-1:0] chunk_addr(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y,
                                                     input int            cols);
        return ADDR_W'(y) * ADDR_W'(cols) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/chunk_scheduler_if.sv
// Bundle of the request, board-memory, drawer and status signals around the
// chunk scheduler; slave is the scheduler's view, master the surrounding system.
interface chunk_scheduler_if;
    logic        start_full;
    logic        req_valid;
    logic [5:0]  req_x;
    logic [4:0]  req_y;
    logic        req_ready;
    logic [10:0] mem_addr;
    logic [1:0]  mem_data;
    logic        drw_reset;
    logic [5:0]  drw_x_chunk;
    logic [4:0]  drw_y_chunk;
    logic [1:0]  drw_data;
    logic        drw_done;
    logic        pixel_we;
    logic        busy;
    logic        frame_done;

    modport slave (
        input  start_full, req_valid, req_x, req_y, mem_data, drw_done,
        output req_ready, mem_addr, drw_reset, drw_x_chunk, drw_y_chunk,
               drw_data, pixel_we, busy, frame_done
    );

    modport master (
        output start_full, req_valid, req_x, req_y, mem_data, drw_done,
        input  req_ready, mem_addr, drw_reset, drw_x_chunk, drw_y_chunk,
               drw_data, pixel_we, busy, frame_done
    );
endinterface

// File: rtl/chunk_scheduler_coord.sv
// Row-major chunk coordinate counter: loadable cx/cy, x-fastest increment, a
// linear address kept in step with the coordinates, and a last-chunk flag.
module chunk_coord_counter
    import chunk_pkg::*;
#(
    parameter int COLS = 40,
    parameter int ROWS = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        inc,
    input  logic [5:0]  load_x,
    input  logic [4:0]  load_y,
    output logic [5:0]  cx,
    output logic [4:0]  cy,
    output logic [10:0] addr,
    output logic        last
);

    localparam logic [5:0] LAST_X = 6'(COLS - 1);
    localparam logic [4:0] LAST_Y = 5'(ROWS - 1);

    logic at_last_x_s;

    assign at_last_x_s = (cx == LAST_X);
    assign last        = at_last_x_s && (cy == LAST_Y);

    // Address tracks cx/cy so it is valid in the same cycle the coordinates are.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cx   <= 6'd0;
            cy   <= 5'd0;
            addr <= 11'd0;
        end else if (load) begin
            cx   <= load_x;
            cy   <= load_y;
            addr <= chunk_addr(load_x, load_y, COLS);
        end else if (inc) begin
            if (at_last_x_s) begin
                cx <= 6'd0;
                cy <= (cy == LAST_Y) ? 5'd0 : cy + 5'd1;
            end else begin
                cx <= cx + 6'd1;
            end
            addr <= last ? 11'd0 : addr + 11'd1;
        end
    end

endmodule

// File: rtl/chunk_scheduler.sv
// Sequences the chunk drawer over the frame (full redraw) or one chunk (single
// request): fetch cell code, restart drawer, gate pixel writes, flag completion.
module chunk_scheduler #(
    parameter int CHUNK_COLS  = chunk_pkg::CHUNK_COLS,
    parameter int CHUNK_ROWS  = chunk_pkg::CHUNK_ROWS,
    parameter int MEM_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    chunk_scheduler_if.slave bus
);
    import chunk_pkg::*;

    localparam logic [6:0] X_LIMIT   = 7'(CHUNK_COLS);
    localparam logic [5:0] Y_LIMIT   = 6'(CHUNK_ROWS);
    localparam logic [1:0] WAIT_LAST = 2'(MEM_LATENCY - 1);

    state_e      state_r;
    mode_e       mode_r;
    logic [1:0]  wait_r;
    logic        run_r;
    logic        draw_active_r;
    logic        drw_reset_r;
    logic        frame_done_r;
    logic        busy_r;
    logic [5:0]  drw_x_r;
    logic [4:0]  drw_y_r;
    logic [1:0]  drw_data_r;

    logic        req_ready_s;
    logic        accept_s;
    logic        in_range_s;
    logic        load_s;
    logic        inc_s;
    logic [5:0]  load_x_s;
    logic [4:0]  load_y_s;
    logic [5:0]  cx_s;
    logic [4:0]  cy_s;
    logic [10:0] addr_s;
    logic        last_s;

    chunk_coord_counter #(
        .COLS (CHUNK_COLS),
        .ROWS (CHUNK_ROWS)
    ) u_coord (
        .clk    (clk),
        .reset  (reset),
        .load   (load_s),
        .inc    (inc_s),
        .load_x (load_x_s),
        .load_y (load_y_s),
        .cx     (cx_s),
        .cy     (cy_s),
        .addr   (addr_s),
        .last   (last_s)
    );

    // Request handshake and coordinate-counter control.
    always_comb begin
        req_ready_s = run_r && (state_r == IDLE) && !bus.start_full;
        accept_s    = req_ready_s && bus.req_valid;
        in_range_s  = ({1'b0, bus.req_x} < X_LIMIT) && ({1'b0, bus.req_y} < Y_LIMIT);
        load_s      = 1'b0;
        inc_s       = 1'b0;
        load_x_s    = 6'd0;
        load_y_s    = 5'd0;
        case (state_r)
            IDLE: begin
                if (bus.start_full) begin
                    load_s = 1'b1;
                end else if (accept_s && in_range_s) begin
                    load_s   = 1'b1;
                    load_x_s = bus.req_x;
                    load_y_s = bus.req_y;
                end else begin
                    load_s = 1'b0;
                end
            end
            NEXT: begin
                if ((mode_r == FULL) && !last_s) begin
                    inc_s = 1'b1;
                end else begin
                    inc_s = 1'b0;
                end
            end
            default: begin
                load_s = 1'b0;
                inc_s  = 1'b0;
            end
        endcase
    end

    // Main sequencer with registered drawer/status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            mode_r        <= FULL;
            wait_r        <= 2'd0;
            run_r         <= 1'b0;
            draw_active_r <= 1'b0;
            drw_reset_r   <= 1'b1;
            frame_done_r  <= 1'b0;
            busy_r        <= 1'b0;
            drw_x_r       <= 6'd0;
            drw_y_r       <= 5'd0;
            drw_data_r    <= 2'd0;
        end else begin
            run_r        <= 1'b1;
            frame_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start_full) begin
                        state_r <= FETCH;
                        mode_r  <= FULL;
                        wait_r  <= 2'd0;
                        busy_r  <= 1'b1;
                    end else if (accept_s) begin
                        if (in_range_s) begin
                            state_r <= FETCH;
                            mode_r  <= SINGLE;
                            wait_r  <= 2'd0;
                            busy_r  <= 1'b1;
                        end else begin
                            frame_done_r <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (wait_r == WAIT_LAST) begin
                        state_r <= LATCH;
                    end else begin
                        wait_r <= wait_r + 2'd1;
                    end
                end
                LATCH: begin
                    drw_data_r  <= bus.mem_data;
                    drw_x_r     <= cx_s;
                    drw_y_r     <= cy_s;
                    drw_reset_r <= 1'b0;
                    state_r     <= DRAW;
                end
                DRAW: begin
                    // The drawer's first pixel lags its counters, so writes open one cycle in.
                    if (bus.drw_done) begin
                        state_r       <= NEXT;
                        drw_reset_r   <= 1'b1;
                        draw_active_r <= 1'b0;
                        frame_done_r  <= (mode_r == SINGLE) || last_s;
                    end else begin
                        draw_active_r <= 1'b1;
                    end
                end
                NEXT: begin
                    if ((mode_r == SINGLE) || last_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= FETCH;
                        wait_r  <= 2'd0;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    busy_r        <= 1'b0;
                    drw_reset_r   <= 1'b1;
                    draw_active_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_s;
    assign bus.mem_addr    = addr_s;
    assign bus.drw_reset   = drw_reset_r;
    assign bus.drw_x_chunk = drw_x_r;
    assign bus.drw_y_chunk = drw_y_r;
    assign bus.drw_data    = drw_data_r;
    assign bus.pixel_we    = draw_active_r && !bus.drw_done;
    assign bus.busy        = busy_r;
    assign bus.frame_done  = frame_done_r;

endmodule

// File: tb/tb_chunk_scheduler.sv
// Self-checking bench for chunk_scheduler: board memory and drawer models, a
// vector table, random single requests, a full frame, latency-2 and reset cases.
module tb_chunk_scheduler;
    import chunk_pkg::*;

    typedef struct { int x; int y; int data; int addr; } restart_t;
    typedef struct {
        int x; int y; int data;
        int exp_addr; int exp_x; int exp_y; int exp_data; int exp_pwe;
    } vec_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         draw_len = 256;
    int         dcnt1 = 0;
    int         dcnt2 = 0;
    logic [1:0] mem1 [0:1199];
    logic [1:0] mem2 [0:1199];
    logic [1:0] mem2_d1 = 2'd0;

    restart_t   restarts[$];
    int         pwe_cnt;
    int         fd_cnt;
    int         fd_first;
    bit         busy_seen;
    bit         end_ready;

    always #5 clk = ~clk;

    chunk_scheduler_if bus1 ();
    chunk_scheduler_if bus2 ();

    chunk_scheduler #(.CHUNK_COLS(40), .CHUNK_ROWS(30), .MEM_LATENCY(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    chunk_scheduler #(.CHUNK_COLS(40), .CHUNK_ROWS(30), .MEM_LATENCY(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    // Board memories: one- and two-cycle synchronous read.
    always @(posedge clk) begin
        bus1.mem_data <= (bus1.mem_addr < 11'd1200) ? mem1[bus1.mem_addr] : 2'd0;
        mem2_d1       <= (bus2.mem_addr < 11'd1200) ? mem2[bus2.mem_addr] : 2'd0;
        bus2.mem_data <= mem2_d1;
    end

    // Drawer models: draw_len valid pixels after a one-cycle pipeline fill.
    always @(posedge clk) begin
        if (bus1.drw_reset) dcnt1 <= 0;
        else if (dcnt1 <= draw_len) dcnt1 <= dcnt1 + 1;
        if (bus2.drw_reset) dcnt2 <= 0;
        else if (dcnt2 <= draw_len) dcnt2 <= dcnt2 + 1;
    end
    assign bus1.drw_done = (dcnt1 > draw_len);
    assign bus2.drw_done = (dcnt2 > draw_len);

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send_req(input int x, input int y);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        bus1.req_x     = 6'(x);
        bus1.req_y     = 5'(y);
        bus1.req_valid = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            #1;
            if (bus1.req_ready) ok = 1'b1;
            else @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            check("req_accept_timeout", 0, 1);
        end
        bus1.req_valid = 1'b0;
    endtask

    // Sample bus1 each cycle until frame_done has been seen and the DUT is idle.
    task automatic observe(input int max_cycles, input int extra);
        bit prev_drst;
        bit done;
        restarts.delete();
        pwe_cnt = 0; fd_cnt = 0; fd_first = -1; busy_seen = 1'b0; end_ready = 1'b0;
        prev_drst = 1'b1;
        done = 1'b0;
        for (int n = 1; n <= max_cycles + extra; n++) begin
            if (done && extra == 0) break;
            @(negedge clk);
            if (bus1.pixel_we) pwe_cnt++;
            if (bus1.busy) busy_seen = 1'b1;
            if (bus1.frame_done) begin
                fd_cnt++;
                if (fd_first < 0) fd_first = n;
            end
            if (prev_drst && !bus1.drw_reset)
                restarts.push_back('{int'(bus1.drw_x_chunk), int'(bus1.drw_y_chunk),
                                    int'(bus1.drw_data), int'(bus1.mem_addr)});
            prev_drst = bus1.drw_reset;
            if (!done && fd_cnt > 0 && !bus1.busy) begin
                done = 1'b1;
                end_ready = bus1.req_ready;
                max_cycles = n;
            end
        end
        if (!done) check("observe_timeout", 0, 1);
    endtask

    function automatic int first_field(input int which);
        if (restarts.size() == 0) return -1;
        case (which)
            0: return restarts[0].addr;
            1: return restarts[0].x;
            2: return restarts[0].y;
            default: return restarts[0].data;
        endcase
    endfunction

    vec_t vecs[8];

    initial begin
        int rx, ry, rd, raddr, errs, got;
        bit in_rng;
        vecs[0] = '{4,  4,  2, 164,  4,  4,  2, 256};
        vecs[1] = '{0,  0,  1, 0,    0,  0,  1, 256};
        vecs[2] = '{39, 29, 3, 1199, 39, 29, 3, 256};
        vecs[3] = '{39, 0,  0, 39,   39, 0,  0, 256};
        vecs[4] = '{0,  1,  3, 40,   0,  1,  3, 256};
        vecs[5] = '{45, 0,  1, -1,   -1, -1, -1, 0};
        vecs[6] = '{0,  30, 2, -1,   -1, -1, -1, 0};
        vecs[7] = '{63, 31, 1, -1,   -1, -1, -1, 0};

        for (int i = 0; i < 1200; i++) begin
            mem1[i] = 2'($urandom_range(0, 3));
            mem2[i] = 2'($urandom_range(0, 2));
        end
        mem2[0] = 2'd0; mem2[1199] = 2'd3;
        bus1.start_full = 1'b0; bus1.req_valid = 1'b0; bus1.req_x = 6'd0; bus1.req_y = 5'd0;
        bus2.start_full = 1'b0; bus2.req_valid = 1'b0; bus2.req_x = 6'd0; bus2.req_y = 5'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", int'(bus1.busy), 0);
        check("rst_drw_reset", int'(bus1.drw_reset), 1);
        check("rst_pixel_we", int'(bus1.pixel_we), 0);
        check("rst_frame_done", int'(bus1.frame_done), 0);
        check("rst_req_ready", int'(bus1.req_ready), 0);
        check("rst_mem_addr", int'(bus1.mem_addr), 0);
        check("rst_drw_x", int'(bus1.drw_x_chunk), 0);
        check("rst_drw_y", int'(bus1.drw_y_chunk), 0);
        check("rst_drw_data", int'(bus1.drw_data), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_req_ready", int'(bus1.req_ready), 1);

        // Vector table: single requests with a full 16x16 drawer
        draw_len = 256;
        foreach (vecs[i]) begin
            if (vecs[i].exp_addr >= 0) mem1[vecs[i].exp_addr] = 2'(vecs[i].data);
            send_req(vecs[i].x, vecs[i].y);
            observe(600, 2);
            check($sformatf("vec%0d_frame_done", i), fd_cnt, 1);
            check($sformatf("vec%0d_addr", i), first_field(0), vecs[i].exp_addr);
            check($sformatf("vec%0d_x", i), first_field(1), vecs[i].exp_x);
            check($sformatf("vec%0d_y", i), first_field(2), vecs[i].exp_y);
            check($sformatf("vec%0d_data", i), first_field(3), vecs[i].exp_data);
            check($sformatf("vec%0d_pixel_we", i), pwe_cnt, vecs[i].exp_pwe);
            check($sformatf("vec%0d_restarts", i), restarts.size(), vecs[i].exp_addr >= 0 ? 1 : 0);
            if (vecs[i].exp_addr < 0) begin
                check($sformatf("vec%0d_oor_fd_delay", i), fd_first, 1);
                check($sformatf("vec%0d_oor_busy", i), int'(busy_seen), 0);
            end
        end

        // Random single requests against the reference rules
        for (int k = 0; k < 24; k++) begin
            draw_len = $urandom_range(1, 6);
            rx = $urandom_range(0, 47);
            ry = $urandom_range(0, 31);
            rd = $urandom_range(0, 3);
            in_rng = (rx < CHUNK_COLS) && (ry < CHUNK_ROWS);
            raddr = in_rng ? ry * CHUNK_COLS + rx : -1;
            if (in_rng) mem1[raddr] = 2'(rd);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_req(rx, ry);
            observe(100, 2);
            check($sformatf("rnd%0d_frame_done", k), fd_cnt, 1);
            check($sformatf("rnd%0d_restarts", k), restarts.size(), in_rng ? 1 : 0);
            check($sformatf("rnd%0d_addr", k), first_field(0), raddr);
            check($sformatf("rnd%0d_data", k), first_field(3), in_rng ? rd : -1);
            check($sformatf("rnd%0d_pixel_we", k), pwe_cnt, in_rng ? draw_len : 0);
        end

        // Full frame, with a competing request raised in the same cycle
        for (int i = 0; i < 1200; i++) mem1[i] = 2'(i);
        draw_len = 4;
        @(negedge clk);
        bus1.start_full = 1'b1;
        bus1.req_valid  = 1'b1;
        bus1.req_x      = 6'd1;
        bus1.req_y      = 5'd0;
        #1;
        check("same_cycle_req_ready", int'(bus1.req_ready), 0);
        @(posedge clk);
        #1;
        bus1.start_full = 1'b0;
        observe(20000, 0);
        check("full_restarts", restarts.size(), 1200);
        errs = 0;
        foreach (restarts[i]) begin
            if (restarts[i].x != i % 40 || restarts[i].y != i / 40 ||
                restarts[i].addr != i || restarts[i].data != (i & 3)) errs++;
        end
        check("full_order_errors", errs, 0);
        check("full_last_addr", restarts.size() > 0 ? restarts[restarts.size()-1].addr : -1, 1199);
        check("full_frame_done", fd_cnt, 1);
        check("full_pixel_we", pwe_cnt, 4800);
        check("held_req_ready_back_in_idle", int'(end_ready), 1);
        @(posedge clk);
        #1;
        bus1.req_valid = 1'b0;
        observe(100, 2);
        check("held_req_restarts", restarts.size(), 1);
        check("held_req_x", first_field(1), 1);
        check("held_req_y", first_field(2), 0);
        check("held_req_frame_done", fd_cnt, 1);

        // Two-cycle memory latency: captured code must be the word at 1199
        draw_len = 3;
        @(negedge clk);
        bus2.req_x = 6'd39; bus2.req_y = 5'd29; bus2.req_valid = 1'b1;
        #1;
        check("l2_req_ready", int'(bus2.req_ready), 1);
        @(posedge clk);
        #1;
        bus2.req_valid = 1'b0;
        got = 0;
        for (int n = 0; n < 40 && got == 0; n++) begin
            @(negedge clk);
            if (!bus2.drw_reset) begin
                got = 1;
                check("l2_mem_addr", int'(bus2.mem_addr), 1199);
                check("l2_drw_x", int'(bus2.drw_x_chunk), 39);
                check("l2_drw_y", int'(bus2.drw_y_chunk), 29);
                check("l2_drw_data", int'(bus2.drw_data), 3);
            end
        end
        check("l2_drawer_started", got, 1);
        got = 0;
        for (int n = 0; n < 40 && got == 0; n++) begin
            @(negedge clk);
            if (bus2.frame_done) got = 1;
        end
        check("l2_frame_done", got, 1);

        // Asynchronous reset in the middle of a draw
        draw_len = 256;
        send_req(10, 5);
        got = 0;
        for (int n = 0; n < 20 && got == 0; n++) begin
            @(negedge clk);
            if (!bus1.drw_reset) got = 1;
        end
        check("mid_draw_reached", got, 1);
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", int'(bus1.busy), 0);
        check("abort_drw_reset", int'(bus1.drw_reset), 1);
        check("abort_pixel_we", int'(bus1.pixel_we), 0);
        fd_cnt = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (bus1.frame_done || bus1.pixel_we) fd_cnt++;
        end
        reset = 1'b1;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            if (bus1.frame_done) fd_cnt++;
        end
        check("abort_no_frame_done", fd_cnt, 0);
        check("abort_release_req_ready", int'(bus1.req_ready), 1);
        check("abort_release_busy", int'(bus1.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no end of test, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
